// File: rtl/sdram_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
// Holds the FSM state encoding, the default access timeout and the port count.
package sdram_pkg;

  localparam int unsigned NumPorts       = 2;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [2:0] {
    StKick,
    StInit,
    StIdle,
    StIssue,
    StGuard,
    StWrite,
    StRead
  } state_e;

endpackage

// File: rtl/sdram_rr_arb.sv
// Two-way round-robin picker.
// Ports:
//   req        - request vector, one bit per port
//   last_grant - index of the port granted most recently
//   grant      - index of the chosen port (meaningful only when any=1)
//   any        - at least one port is requesting
module sdram_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |req;
    // On a tie the port that did not win last time goes next.
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Two-port arbiter in front of a single SDRAM controller.
// Kicks controller initialisation after reset, then grants one access at a
// time round-robin, waits for write completion (mem_rdy) or read data
// (mem_valid), and abandons an access that outlives TIMEOUT cycles.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata  - request from port N, held until reqN_ack
//   reqN_ack/rdata/rvalid/done- grant pulse, read data, read strobe, completion
//   mem_en/we/addr/wdata      - command to the controller
//   mem_rdy/valid/rdata       - controller idle flag, read strobe, read data
//   init_done, busy, err      - status; err is sticky until reset
// Every output is a register.
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned TIMEOUT   = DefaultTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_wdata,
  output logic                 req0_ack,
  output logic [DATA_BITS-1:0] req0_rdata,
  output logic                 req0_rvalid,
  output logic                 req0_done,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_wdata,
  output logic                 req1_ack,
  output logic [DATA_BITS-1:0] req1_rdata,
  output logic                 req1_rvalid,
  output logic                 req1_done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_rdy,
  input  logic                 mem_valid,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 init_done,
  output logic                 busy,
  output logic                 err
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic [7:0]            wdog_q, wdog_d, wdog_inc;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NumPorts-1:0]   ack_q, ack_d, rvalid_q, rvalid_d, done_q, done_d;
  logic [DATA_BITS-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  init_done_q, init_done_d, busy_q, busy_d, err_q, err_d;
  logic                  grant, any;
  logic                  complete;

  sdram_rr_arb u_rr_arb (
    .req       ({req1_valid, req0_valid}),
    .last_grant(last_q),
    .grant     (grant),
    .any       (any)
  );

  assign wdog_inc = wdog_q + 8'd1;
  assign complete = (state_q == StWrite) ? mem_rdy : mem_valid;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    wdog_d      = wdog_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    rvalid_d    = '0;
    done_d      = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    unique case (state_q)
      StKick: begin
        mem_en_d = 1'b1;
        state_d  = StInit;
      end
      StInit: begin
        if (mem_rdy) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIdle: begin
        if (mem_rdy && any) begin
          mem_en_d     = 1'b1;
          ack_d[grant] = 1'b1;
          last_d       = grant;
          port_d       = grant;
          mem_we_d     = grant ? req1_we    : req0_we;
          mem_addr_d   = grant ? req1_addr  : req0_addr;
          mem_wdata_d  = grant ? req1_wdata : req0_wdata;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StGuard;
      end
      // Controller needs a cycle to drop rdy after the command; ignore it here.
      StGuard: state_d = mem_we_q ? StWrite : StRead;
      StWrite, StRead: begin
        wdog_d = wdog_inc;
        // Completion is tested first so it wins over a coincident timeout.
        if (complete) begin
          done_d[port_q] = 1'b1;
          if (state_q == StRead) begin
            rvalid_d[port_q] = 1'b1;
            if (port_q) rdata1_d = mem_rdata;
            else        rdata0_d = mem_rdata;
          end
          state_d = StIdle;
        end else if (wdog_inc == TimeoutCnt) begin
          err_d          = 1'b1;
          done_d[port_q] = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StKick;
    endcase
    busy_d = state_d inside {StIssue, StGuard, StWrite, StRead};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StKick;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      wdog_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      done_q      <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      wdog_q      <= wdog_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign req0_ack    = ack_q[0];
  assign req1_ack    = ack_q[1];
  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: init handshake, round-robin reads, a write,
// reset mid-read, completion coinciding with the watchdog, and a timeout.
module tb_sdram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ack, req0_rvalid, req0_done;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [11:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ack, req1_rvalid, req1_done;
  logic [31:0] req1_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy = 1'b0, mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        init_done, busy, err;

  int checks   = 0;
  int failures = 0;

  localparam int Timeout = 255;

  sdram_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ack   (req0_ack),
    .req0_rdata (req0_rdata),
    .req0_rvalid(req0_rvalid),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ack   (req1_ack),
    .req1_rdata (req1_rdata),
    .req1_rvalid(req1_rvalid),
    .req1_done  (req1_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .init_done  (init_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=hung required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read: mem_valid appears 3 cycles after mem_en, rdy returns one cycle
  // after the data so the idle cycle in between must not re-arbitrate.
  task automatic read_txn(input bit port, input logic [11:0] addr, input logic [31:0] rd);
    step();
    check("rd_ack_win",  port ? req1_ack : req0_ack, 1);
    check("rd_ack_lose", port ? req0_ack : req1_ack, 0);
    check("rd_mem_en",   mem_en, 1);
    check("rd_mem_we",   mem_we, 0);
    check("rd_mem_addr", mem_addr, addr);
    mem_rdy = 1'b0;
    step();
    check("rd_en_pulse", mem_en, 0);
    step();
    step();
    check("rd_busy", busy, 1);
    check("rd_no_early_done", port ? req1_done : req0_done, 0);
    mem_valid = 1'b1;
    mem_rdata = rd;
    step();
    mem_valid = 1'b0;
    mem_rdata = ~rd;
    check("rd_rvalid",      port ? req1_rvalid : req0_rvalid, 1);
    check("rd_done",        port ? req1_done : req0_done, 1);
    check("rd_rvalid_lose", port ? req0_rvalid : req1_rvalid, 0);
    check("rd_rdata",       port ? req1_rdata : req0_rdata, rd);
    check("rd_idle_busy",   busy, 0);
    step();
    check("rd_no_rearb", mem_en, 0);
    check("rd_rv_pulse", port ? req1_rvalid : req0_rvalid, 0);
    check("rd_hold",     port ? req1_rdata : req0_rdata, rd);
    mem_rdy = 1'b1;
  endtask

  initial begin
    // Reset values
    #2 rst = 1'b1;
    step();
    step();
    check("rst_mem_en", mem_en, 0);
    check("rst_init",   init_done, 0);
    check("rst_busy",   busy, 0);
    check("rst_err",    err, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_rdata0", req0_rdata, 0);

    // Init: mem_en pulses right after release, rdy held low for 20 cycles
    rst = 1'b0;
    step();
    check("kick_en", mem_en, 1);
    check("kick_init", init_done, 0);
    for (int i = 0; i < 19; i++) begin
      step();
      check("init_en_low", mem_en, 0);
    end
    check("init_wait", init_done, 0);
    mem_rdy = 1'b1;
    step();
    check("init_done", init_done, 1);

    // Both ports read continuously: first tie goes to port 0, then alternate
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h100;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h201;
    read_txn(1'b0, 12'h100, 32'h1111_1111);
    read_txn(1'b1, 12'h201, 32'h2222_2222);
    read_txn(1'b0, 12'h100, 32'h3333_3333);
    read_txn(1'b1, 12'h201, 32'h4444_4444);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Port 0 write
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h0A5; req0_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_en",    mem_en, 1);
    check("wr_we",    mem_we, 1);
    check("wr_addr",  mem_addr, 12'h0A5);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_ack0",  req0_ack, 1);
    check("wr_ack1",  req1_ack, 0);
    check("wr_busy",  busy, 1);
    req0_valid = 1'b0;
    req0_addr  = 12'h000;
    req0_wdata = 32'h0;
    mem_rdy    = 1'b0;
    step();
    check("wr_en_pulse", mem_en, 0);
    check("wr_ack_pulse", req0_ack, 0);
    check("wr_addr_hold", mem_addr, 12'h0A5);
    check("wr_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
    step();
    step();
    check("wr_wait_done", req0_done, 0);
    mem_rdy = 1'b1;
    step();
    check("wr_done0", req0_done, 1);
    check("wr_done1", req1_done, 0);
    check("wr_rvalid", req0_rvalid, 0);
    check("wr_idle_busy", busy, 0);
    step();
    check("wr_done_pulse", req0_done, 0);

    // Reset while in READ on port 1
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h2AA;
    step();
    check("mr_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    mem_rdy    = 1'b0;
    step();
    step();
    check("mr_in_read", busy, 1);
    rst = 1'b1;
    #1;
    check("mr_busy",   busy, 0);
    check("mr_init",   init_done, 0);
    check("mr_addr",   mem_addr, 0);
    check("mr_rdata0", req0_rdata, 0);
    check("mr_rdata1", req1_rdata, 0);
    check("mr_we",     mem_we, 0);
    step();
    check("mr_no_done", req1_done, 0);
    rst = 1'b0;
    step();
    check("mr_kick", mem_en, 1);
    step();
    check("mr_kick_pulse", mem_en, 0);
    mem_rdy = 1'b1;
    step();
    check("mr_init_done", init_done, 1);

    // Read data arrives in the very cycle the watchdog expires
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h3C3;
    step();
    check("co_ack0", req0_ack, 1);
    req0_valid = 1'b0;
    mem_rdy    = 1'b0;
    step();
    step();
    for (int i = 1; i < Timeout; i++) step();
    check("co_pre_done", req0_done, 0);
    check("co_pre_busy", busy, 1);
    mem_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_valid = 1'b0;
    mem_rdy   = 1'b1;
    check("co_rvalid", req0_rvalid, 1);
    check("co_done",   req0_done, 1);
    check("co_rdata",  req0_rdata, 32'hCAFE_F00D);
    check("co_err",    err, 0);

    // Port 1 read with no data: watchdog abandons it
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h2F0;
    step();
    check("to_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    mem_rdy    = 1'b0;
    step();
    step();
    for (int i = 1; i < Timeout; i++) step();
    check("to_pre_err",  err, 0);
    check("to_pre_done", req1_done, 0);
    step();
    check("to_err",    err, 1);
    check("to_done",   req1_done, 1);
    check("to_rvalid", req1_rvalid, 0);
    check("to_rdata",  req1_rdata, 0);
    check("to_busy",   busy, 0);
    step();
    check("to_sticky", err, 1);
    check("to_done_pulse", req1_done, 0);

    // Next request still serviced; rdy during GUARD must be ignored
    mem_rdy = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h055; req0_wdata = 32'h1234_5678;
    step();
    check("nx_ack0",  req0_ack, 1);
    check("nx_addr",  mem_addr, 12'h055);
    check("nx_wdata", mem_wdata, 32'h1234_5678);
    req0_valid = 1'b0;
    mem_rdy    = 1'b0;
    step();
    mem_rdy = 1'b1;
    step();
    check("nx_guard", req0_done, 0);
    step();
    check("nx_done", req0_done, 1);
    check("nx_err",  err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
